// File: rtl/kf_hv_stream_serializer.sv
// Double-buffered hypervector operand serializer: parallel A/B word pairs in,
// two lock-step LSB-first bit streams out with vector framing and counters.
module kf_hv_stream_serializer #(
   parameter int unsigned HYPERVEC_DIM = 8192,
   parameter int unsigned WORD_WIDTH   = 64,
   parameter int unsigned VCOUNT_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WORD_WIDTH-1:0]   word_a,
   input  logic [WORD_WIDTH-1:0]   word_b,
   input  logic                    word_valid,
   output logic                    word_ready,
   input  logic                    abort,
   output logic                    bit_a,
   output logic                    bit_b,
   output logic                    bit_valid,
   input  logic                    out_ready,
   output logic                    vec_start,
   output logic                    vec_last,
   output logic                    underrun_err,
   output logic [VCOUNT_WIDTH-1:0] vec_count
);

   localparam int unsigned WORDS_PER_VEC = HYPERVEC_DIM / WORD_WIDTH;
   localparam int unsigned BIDX_W = $clog2(WORD_WIDTH);
   localparam int unsigned WIDX_W = (WORDS_PER_VEC > 1) ? $clog2(WORDS_PER_VEC) : 1;
   localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(WORD_WIDTH - 1);
   localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WORDS_PER_VEC - 1);

   if (WORD_WIDTH < 2 || (WORD_WIDTH & (WORD_WIDTH - 1)) != 0) begin : g_bad_word_width
      $error("WORD_WIDTH must be a power of two and at least 2");
   end
   if (HYPERVEC_DIM == 0 || (HYPERVEC_DIM % WORD_WIDTH) != 0) begin : g_bad_dim
      $error("HYPERVEC_DIM must be a non-zero multiple of WORD_WIDTH");
   end

   logic [WORD_WIDTH-1:0]   shift_a_q, shift_a_d, shift_b_q, shift_b_d;
   logic [WORD_WIDTH-1:0]   hold_a_q, hold_a_d, hold_b_q, hold_b_d;
   logic                    shift_full_q, shift_full_d;
   logic                    hold_full_q, hold_full_d;
   logic [BIDX_W-1:0]       bit_idx_q, bit_idx_d;
   logic [WIDX_W-1:0]       word_idx_q, word_idx_d;
   logic                    underrun_q, underrun_d;
   logic [VCOUNT_WIDTH-1:0] vec_count_q, vec_count_d;

   logic accept, consume, word_done, shift_free;

   assign word_ready   = !hold_full_q && !rst && !abort;
   assign bit_valid    = shift_full_q;
   assign bit_a        = shift_a_q[0];
   assign bit_b        = shift_b_q[0];
   assign vec_start    = shift_full_q && (word_idx_q == '0) && (bit_idx_q == '0);
   assign vec_last     = shift_full_q && (word_idx_q == WIDX_LAST) && (bit_idx_q == BIDX_LAST);
   assign underrun_err = underrun_q;
   assign vec_count    = vec_count_q;

   assign accept     = word_valid && word_ready;
   assign consume    = shift_full_q && out_ready;
   assign word_done  = bit_idx_q == BIDX_LAST;
   // SHIFT may be refilled in the same cycle its final bit is taken: no bubble.
   assign shift_free = !shift_full_q || (consume && word_done);

   always_comb begin
      shift_a_d    = shift_a_q;
      shift_b_d    = shift_b_q;
      hold_a_d     = hold_a_q;
      hold_b_d     = hold_b_q;
      shift_full_d = shift_full_q;
      hold_full_d  = hold_full_q;
      bit_idx_d    = bit_idx_q;
      word_idx_d   = word_idx_q;
      underrun_d   = underrun_q;
      vec_count_d  = vec_count_q;

      if (abort) begin
         shift_a_d    = '0;
         shift_b_d    = '0;
         hold_a_d     = '0;
         hold_b_d     = '0;
         shift_full_d = 1'b0;
         hold_full_d  = 1'b0;
         bit_idx_d    = '0;
         word_idx_d   = '0;
         underrun_d   = 1'b0;
      end else begin
         if (consume) begin
            shift_a_d = shift_a_q >> 1;
            shift_b_d = shift_b_q >> 1;
            if (word_done) begin
               bit_idx_d = '0;
               if (word_idx_q == WIDX_LAST) begin
                  word_idx_d  = '0;
                  vec_count_d = vec_count_q + 1'b1;
               end else begin
                  word_idx_d = word_idx_q + 1'b1;
               end
            end else begin
               bit_idx_d = bit_idx_q + 1'b1;
            end
         end

         if (shift_free) begin
            if (hold_full_q) begin
               shift_a_d    = hold_a_q;
               shift_b_d    = hold_b_q;
               shift_full_d = 1'b1;
               hold_full_d  = accept;
               if (accept) begin
                  hold_a_d = word_a;
                  hold_b_d = word_b;
               end
            end else if (accept) begin
               shift_a_d    = word_a;
               shift_b_d    = word_b;
               shift_full_d = 1'b1;
            end else begin
               shift_full_d = 1'b0;
            end
         end else if (accept) begin
            hold_a_d    = word_a;
            hold_b_d    = word_b;
            hold_full_d = 1'b1;
         end

         // Starved after the vector began; idle at (0,0) is legitimate.
         if (!shift_full_q && ((word_idx_q != '0) || (bit_idx_q != '0))) begin
            underrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_a_q    <= '0;
         shift_b_q    <= '0;
         hold_a_q     <= '0;
         hold_b_q     <= '0;
         shift_full_q <= 1'b0;
         hold_full_q  <= 1'b0;
         bit_idx_q    <= '0;
         word_idx_q   <= '0;
         underrun_q   <= 1'b0;
         vec_count_q  <= '0;
      end else begin
         shift_a_q    <= shift_a_d;
         shift_b_q    <= shift_b_d;
         hold_a_q     <= hold_a_d;
         hold_b_q     <= hold_b_d;
         shift_full_q <= shift_full_d;
         hold_full_q  <= hold_full_d;
         bit_idx_q    <= bit_idx_d;
         word_idx_q   <= word_idx_d;
         underrun_q   <= underrun_d;
         vec_count_q  <= vec_count_d;
      end
   end

endmodule

// File: tb/tb_kf_hv_stream_serializer.sv
// Directed bench for kf_hv_stream_serializer at DIM=64, WORD=16: cycle table
// for reset/stall/abort basics, plus occupancy-tracked streaming sequences.
module tb_kf_hv_stream_serializer;

   logic        clk;
   logic        rst;
   logic [15:0] word_a, word_b;
   logic        word_valid, word_ready;
   logic        abort;
   logic        bit_a, bit_b, bit_valid, out_ready;
   logic        vec_start, vec_last, underrun_err;
   logic [15:0] vec_count;

   int checks = 0;
   int errors = 0;
   int exp_vcnt = 0;
   bit uerr_exp = 1'b0;

   logic [15:0] wa [8];
   logic [15:0] wb [8];

   kf_hv_stream_serializer #(
      .HYPERVEC_DIM(64),
      .WORD_WIDTH  (16),
      .VCOUNT_WIDTH(16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .word_a      (word_a),
      .word_b      (word_b),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .abort       (abort),
      .bit_a       (bit_a),
      .bit_b       (bit_b),
      .bit_valid   (bit_valid),
      .out_ready   (out_ready),
      .vec_start   (vec_start),
      .vec_last    (vec_last),
      .underrun_err(underrun_err),
      .vec_count   (vec_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        valid;
      logic [15:0] a;
      logic [15:0] b;
      logic        abort;
      logic        oready;
      logic [6:0]  exp_out;   // {ready, bit_valid, bit_a, bit_b, vec_start, vec_last, underrun_err}
      logic [15:0] exp_vcnt;
   } vec_t;

   vec_t tbl [10];

   // Inputs are applied 1 time unit after a rising edge; outputs are sampled on
   // the falling edge. Occupancy (words accepted minus words fully shifted out)
   // determines word_ready and bit_valid independently of the DUT.
   task automatic run_stream(input int nwords, input int stop_bits, input int or_mode,
                             input int hold_word, input int hold_cycles, input int exp_gaps);
      int wi = 0, bi = 0, occ, gcnt = 0, gaps = 0, cyc = 0;
      bit offer, acc, cons, stall_prev = 1'b0;
      logic [3:0]  saved = '0;
      logic [15:0] wA, wB;
      while (bi < stop_bits && cyc < 3000) begin
         occ   = wi - bi / 16;
         offer = (wi < nwords) &&
                 !(wi == hold_word && (bi < hold_word * 16 || gcnt < hold_cycles));
         word_valid = offer;
         word_a     = wa[wi % 8];
         word_b     = wb[wi % 8];
         out_ready  = (or_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         @(negedge clk);
         chk("word_ready", word_ready, occ < 2);
         chk("bit_valid", bit_valid, occ > 0);
         chk("underrun_err", underrun_err, uerr_exp);
         chk("vec_count", vec_count, exp_vcnt & 16'hFFFF);
         if (stall_prev) chk("stall_stable", {bit_a, bit_b, vec_start, vec_last}, saved);
         if (occ > 0) begin
            wA = wa[bi / 16];
            wB = wb[bi / 16];
            chk("bit_a", bit_a, wA[bi % 16]);
            chk("bit_b", bit_b, wB[bi % 16]);
            chk("vec_start", vec_start, (bi % 64) == 0);
            chk("vec_last", vec_last, (bi % 64) == 63);
         end
         acc        = offer && (occ < 2);
         cons       = (occ > 0) && out_ready;
         stall_prev = (occ > 0) && !out_ready;
         saved      = {bit_a, bit_b, vec_start, vec_last};
         if (occ == 0 && (bi % 64) != 0) uerr_exp = 1'b1;
         if (occ == 0 && bi > 0) gaps++;
         if (wi == hold_word && bi >= hold_word * 16 && !acc) gcnt++;
         @(posedge clk);
         #1;
         if (acc) wi++;
         if (cons) begin
            if (bi % 64 == 63) exp_vcnt++;
            bi++;
         end
         cyc++;
      end
      chk("cycle_budget", cyc >= 3000, 0);
      chk("gap_cycles", gaps, exp_gaps);
      word_valid = 1'b0;
   endtask

   initial begin
      wa = '{16'hA5F0, 16'h3C96, 16'hFFFF, 16'h0001, 16'h8000, 16'h1234, 16'hDEAD, 16'h5A5A};
      wb = '{16'h0F0F, 16'hF0F0, 16'h0000, 16'h8001, 16'h7FFE, 16'hCAFE, 16'hBEEF, 16'hA5A5};

      //           rst   val   a         b         abt   ordy  {rdy,bv,a,b,st,ls,ue}  vcnt
      tbl[0] = '{1'b1, 1'b1, 16'hA5F0, 16'h0F0F, 1'b0, 1'b0, 7'b0000000, 16'd0};
      tbl[1] = '{1'b0, 1'b1, 16'hA5F0, 16'h0F0F, 1'b0, 1'b0, 7'b1000000, 16'd0};
      tbl[2] = '{1'b0, 1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0, 7'b1101100, 16'd0};
      tbl[3] = '{1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 7'b0101100, 16'd0};
      tbl[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 7'b0101100, 16'd0};
      tbl[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 7'b0101000, 16'd0};
      tbl[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 7'b0101000, 16'd0};
      tbl[7] = '{1'b0, 1'b1, 16'h3333, 16'h4444, 1'b1, 1'b1, 7'b0101000, 16'd0};
      tbl[8] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 7'b1000000, 16'd0};
      tbl[9] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 7'b1000000, 16'd0};

      rst = 1'b1; abort = 1'b0; word_valid = 1'b0; out_ready = 1'b0;
      word_a = '0; word_b = '0;
      repeat (2) @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         rst        = tbl[i].rst;
         word_valid = tbl[i].valid;
         word_a     = tbl[i].a;
         word_b     = tbl[i].b;
         abort      = tbl[i].abort;
         out_ready  = tbl[i].oready;
         @(negedge clk);
         chk($sformatf("table_row%0d_outputs", i),
             {word_ready, bit_valid, bit_a, bit_b, vec_start, vec_last, underrun_err},
             tbl[i].exp_out);
         chk($sformatf("table_row%0d_vec_count", i), vec_count, tbl[i].exp_vcnt);
         @(posedge clk);
         #1;
      end
      rst = 1'b0; abort = 1'b0; word_valid = 1'b0;

      // One full vector, back-to-back, no backpressure.
      run_stream(4, 64, 0, -1, 0, 0);
      // Same vector with out_ready pattern 1,0,0,1.
      run_stream(4, 64, 1, -1, 0, 0);
      // Two vectors from a continuously valid source.
      run_stream(8, 128, 0, -1, 0, 0);
      @(negedge clk);
      chk("vec_count_after_4_vectors", vec_count, 4);
      @(posedge clk);
      #1;

      // Word 2 withheld until 5 starved cycles after bit 31.
      run_stream(4, 64, 0, 2, 4, 5);
      @(negedge clk);
      chk("underrun_sticky", underrun_err, 1);
      chk("vec_count_after_underrun", vec_count, 5);
      @(posedge clk);
      #1;

      // Starve after word 0, then abort once bit 20 has been consumed.
      run_stream(4, 21, 0, 1, 4, 5);
      abort = 1'b1; word_valid = 1'b1; word_a = 16'hFFFF; word_b = 16'hFFFF; out_ready = 1'b1;
      @(negedge clk);
      chk("ready_during_abort", word_ready, 0);
      chk("underrun_before_abort", underrun_err, 1);
      @(posedge clk);
      #1;
      abort = 1'b0; word_valid = 1'b0; uerr_exp = 1'b0;
      @(negedge clk);
      chk("after_abort_outputs", {bit_valid, bit_a, bit_b, vec_start, vec_last, underrun_err}, 0);
      chk("after_abort_vec_count", vec_count, 5);
      @(posedge clk);
      #1;
      run_stream(4, 64, 0, -1, 0, 0);

      // Reset mid-vector with SHIFT and HOLD both occupied.
      run_stream(4, 20, 0, -1, 0, 0);
      rst = 1'b1; word_valid = 1'b1; word_a = 16'hFFFF; word_b = 16'hFFFF; out_ready = 1'b1;
      @(negedge clk);
      chk("ready_during_rst", word_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0; word_valid = 1'b0; exp_vcnt = 0; uerr_exp = 1'b0;
      @(negedge clk);
      chk("after_rst_outputs", {bit_valid, bit_a, bit_b, vec_start, vec_last, underrun_err}, 0);
      chk("after_rst_vec_count", vec_count, 0);
      chk("after_rst_ready", word_ready, 1);
      @(posedge clk);
      #1;
      run_stream(4, 64, 0, -1, 0, 0);
      @(negedge clk);
      chk("final_vec_count", vec_count, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/kf_hv_stream_serializer.md
Name: kf_hv_stream_serializer

Overview:
- Upstream feeder for the bit-serial holographic neurons and the resonant stream.
- Accepts hypervector operand pairs (A, B) as parallel words over a valid/ready handshake.
- Emits them as two lock-step bit streams, LSB-first, with vector framing (start/last).
- Double-buffered: back-to-back words give a gapless stream. It converts memory-width traffic into the "space becomes time" spike-train form the neuron array consumes.

Parameters:
- HYPERVEC_DIM, 8192, bits per hypervector; must be an integer multiple of WORD_WIDTH (elaboration error otherwise).
- WORD_WIDTH, 64, bits per input word; power of two, >=2 (elaboration error otherwise).
- WORDS_PER_VEC, HYPERVEC_DIM/WORD_WIDTH, derived; not overridable.
- VCOUNT_WIDTH, 16, width of completed-vector counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- word_a  in  WORD_WIDTH  operand A word (weight / vector A)
- word_b  in  WORD_WIDTH  operand B word (spike / vector B)
- word_valid  in  1  input word pair valid
- word_ready  out  1  serializer can accept a word pair
- abort  in  1  synchronous flush of the partial vector
- bit_a  out  1  serial A bit
- bit_b  out  1  serial B bit
- bit_valid  out  1  bit_a/bit_b valid
- out_ready  in  1  downstream accepts the bit; tie 1 for the neuron array
- vec_start  out  1  current bit is bit 0 of a vector
- vec_last  out  1  current bit is bit HYPERVEC_DIM-1
- underrun_err  out  1  sticky: stream starved mid-vector
- vec_count  out  VCOUNT_WIDTH  completed vectors, wraps modulo 2^VCOUNT_WIDTH

Behaviour:
- Storage: shift register pair (SHIFT) plus holding register pair (HOLD), each with a full flag.
- Reset (rst=1 at an edge):
  - Clears SHIFT, HOLD, both flags, bit_idx, word_idx, underrun_err, vec_count.
  - All outputs read 0, including word_ready.
  - Any partial vector is discarded.
- word_ready = !HOLD_full && !rst && !abort. It is 1 from the first cycle after reset release.
- Accept = word_valid && word_ready.
- Consume = bit_valid && out_ready.
- bit_valid = SHIFT_full. bit_a/bit_b = SHIFT bit 0, driven straight from registers.
- While bit_valid && !out_ready:
  - bit_a, bit_b, vec_start and vec_last hold stable.
  - No counter advances.
- On Consume:
  - SHIFT shifts right one bit.
  - bit_idx increments.
  - At bit_idx = WORD_WIDTH-1, the word is empty: bit_idx -> 0 and word_idx increments.
  - At word_idx = WORDS_PER_VEC-1, word_idx wraps to 0 and vec_count increments.
- SHIFT load, evaluated at each edge. SHIFT is "free" if it is empty, or if Consume of its last bit happens this cycle.
  - Free and HOLD_full: load HOLD -> SHIFT. If Accept also occurs, the new word goes into HOLD.
  - Free and HOLD empty and Accept: load the input directly into SHIFT (bypass).
  - Not free and Accept: the input goes into HOLD.
- Latency: Accept at edge E with SHIFT free and HOLD empty gives bit_valid=1 in the cycle after E. A continuous word_valid=1 with out_ready=1 gives zero gap cycles.
- vec_start = bit_valid && word_idx==0 && bit_idx==0.
- vec_last = bit_valid && word_idx==WORDS_PER_VEC-1 && bit_idx==WORD_WIDTH-1.
- underrun_err is set when !SHIFT_full and (word_idx,bit_idx) != (0,0), i.e. the vector started but no data. It is cleared only by rst or abort. Idle between vectors is not an error.
- abort (synchronous, priority over Accept/Consume):
  - Next edge clears SHIFT, HOLD, flags, bit_idx, word_idx and underrun_err.
  - vec_count is unchanged.
  - word_ready is 0 while abort=1.
- rst has priority over abort.
- Arithmetic: counters are unsigned. vec_count wraps silently.

Test Plan:
- DIM=64, WORD=16; four pairs A=16'hA5F0.., B=16'h0F0F.. back-to-back, out_ready=1 -> 64 consecutive bit_valid cycles, LSB-first bits match the words. vec_start on cycle 1, vec_last on cycle 64, vec_count=1.
- Same stimulus, out_ready pattern 1,0,0,1 repeating -> no bit lost or duplicated, outputs stable during stalls. word_ready=0 whenever HOLD and SHIFT are both full.
- word_valid held 1 for 8 pairs -> 128 contiguous valid bits, vec_start at bits 0 and 64, vec_count=2. Exactly one Accept per 16 consumed bits in steady state.
- Withhold word 2 for 5 cycles -> bit_valid=0 for 5 cycles after bit 31, underrun_err=1 (sticky). Stream resumes at bit 32 with correct data.
- Assert abort after bit 20 -> bit_valid=0 the next cycle, underrun_err cleared, vec_count unchanged. The next accepted word starts with vec_start=1.
- Assert rst for 1 cycle mid-vector with HOLD full -> all outputs 0 the next cycle, word_ready=0 during rst and 1 after. A fresh vector streams from bit 0 with vec_count=0.
